shiftreg_sequencer: RTL

//  Command-driven controller for the 4-bit bidirectional shift register (shiftregbidir).
//  It accepts one command at a time over a start/ready handshake: load, shift N or rotate N.
//  It drives the register's LD/RL/InS/InP inputs, counts shift cycles and returns the final

---
 rtl/shiftreg_sequencer_if.sv | 25 ++
 rtl/shiftreg_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/shiftreg_sequencer_if.sv
// rtl/shiftreg_sequencer_if.sv - host command/response handshake for the shift register sequencer
interface shiftreg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) ();
    logic             start;
    logic [1:0]       cmd;
    logic             dir;
    logic             fill;
    logic [CNTW-1:0]  amount;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, cmd, dir, fill, amount, data_in,
        input  ready, done, result
    );

    modport slave (
        input  start, cmd, dir, fill, amount, data_in,
        output ready, done, result
    );
endinterface

// File: rtl/shiftreg_sequencer.sv
// rtl/shiftreg_sequencer.sv - command-driven controller for a bidirectional shift register
module shiftreg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic                 CLK,
    input  logic                 Clear,
    shiftreg_sequencer_if.slave  host,
    input  logic [WIDTH-1:0]     D,
    output logic                 LD,
    output logic                 RL,
    output logic                 InS,
    output logic [WIDTH-1:0]     InP
);

    localparam logic [1:0] CMD_LOAD   = 2'b00;
    localparam logic [1:0] CMD_SHIFT  = 2'b01;
    localparam logic [1:0] CMD_ROTATE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] result_q;
    logic [CNTW-1:0]  cnt;
    logic [1:0]       cmd_q;
    logic             dir_q;
    logic             fill_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;

    assign accept = (state == S_IDLE) && host.start;

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            state    <= S_IDLE;
            hold     <= '0;
            result_q <= '0;
            cnt      <= '0;
            cmd_q    <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q  <= host.cmd;
                dir_q  <= host.dir;
                fill_q <= host.fill;
                data_q <= host.data_in;
                cnt    <= host.amount;
            end
            if (state == S_SHIFT) begin
                cnt <= cnt - CNTW'(1);
            end
            if (state == S_CAPTURE) begin
                hold     <= D;
                result_q <= D;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (host.start) begin
                    case (host.cmd)
                        CMD_LOAD:               state_nxt = S_LOAD;
                        CMD_SHIFT, CMD_ROTATE:  state_nxt = (host.amount == '0) ? S_CAPTURE : S_SHIFT;
                        default:                state_nxt = S_CAPTURE;
                    endcase
                end
            end
            S_LOAD:    state_nxt = S_CAPTURE;
            // Counter holds the number of shifts still to happen, including this cycle's.
            S_SHIFT:   state_nxt = (cnt <= CNTW'(1)) ? S_CAPTURE : S_SHIFT;
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The register shifts on every edge with LD=0, so LD stays high outside SHIFT.
    always_comb begin
        LD  = 1'b1;
        RL  = 1'b1;
        InS = 1'b0;
        InP = hold;
        case (state)
            S_LOAD:    InP = data_q;
            S_SHIFT: begin
                LD = 1'b0;
                RL = dir_q;
                if (cmd_q == CMD_ROTATE) begin
                    InS = dir_q ? D[0] : D[WIDTH-1];
                end else begin
                    InS = fill_q;
                end
            end
            S_CAPTURE: InP = D;
            default:   ;
        endcase
    end

    assign host.ready  = (state == S_IDLE);
    assign host.done   = (state == S_DONE);
    assign host.result = result_q;

endmodule
